// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with req/ack handshake and programmable wait states.
// Flags misaligned accesses; rdata is valid in the ack cycle and held until the next ack.
module data_mem_responder #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    logic [1:0]        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              capture, enter_resp;

    logic              lat_we, lat_mis;
    logic [ADDR_W-1:0] lat_idx;
    logic [31:0]       lat_wdata;

    logic              cur_we, cur_mis;
    logic [ADDR_W-1:0] cur_idx;
    logic [31:0]       cur_wdata;

    logic [31:0]       mem [DEPTH];

    // High address bits alias by design and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    // With zero wait states RESP is entered on the capture edge, so live inputs are used there.
    assign cur_we    = (state == IDLE) ? we                       : lat_we;
    assign cur_mis   = (state == IDLE) ? (addr[1:0] != 2'b00)     : lat_mis;
    assign cur_idx   = (state == IDLE) ? addr[ADDR_W+1:2]         : lat_idx;
    assign cur_wdata = (state == IDLE) ? wdata                    : lat_wdata;

    // Next-state and counter logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_W'(WAIT_CYC);
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control state, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack   <= enter_resp;
            err   <= enter_resp && cur_mis;
            busy  <= (state_next != IDLE);
            if (capture) begin
                lat_we    <= we;
                lat_mis   <= (addr[1:0] != 2'b00);
                lat_idx   <= addr[ADDR_W+1:2];
                lat_wdata <= wdata;
            end
            if (enter_resp) begin
                if (cur_mis)     rdata <= 32'h0;
                else if (cur_we) rdata <= cur_wdata;
                else             rdata <= mem[cur_idx];
            end
        end
    end

    // Storage is never reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && cur_we && !cur_mis) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req, we, ack, err, busy;
    logic [31:0] addr, wdata, rdata;

    logic        req0, we0, ack0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        e;
    int          lat;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(6), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    data_mem_responder #(.ADDR_W(6), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the two-wait instance; lat counts edges after capture until ack is seen.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic ef, output int l);
        req = 1'b1; we = w; addr = a; wdata = d;
        l = -1; r = 32'h0; ef = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                l = k; r = rdata; ef = err;
                break;
            end
        end
        req = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;

        // Reset values
        #12;
        check("reset_ack",   32'(ack),   32'h0);
        check("reset_err",   32'(err),   32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_rdata", rdata,      32'h0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        // Store then load
        access(1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat);
        check("store_lat",   32'(lat), 32'd2);
        check("store_echo",  rd,       32'hDEADBEEF);
        access(1'b0, 32'h10, 32'h0, rd, e, lat);
        check("load_lat",    32'(lat), 32'd2);
        check("load_rdata",  rd,       32'hDEADBEEF);
        check("load_err",    32'(e),   32'h0);

        // Misaligned store suppressed
        access(1'b1, 32'h20, 32'h33333333, rd, e, lat);
        access(1'b1, 32'h22, 32'h12345678, rd, e, lat);
        check("mis_lat",     32'(lat), 32'd2);
        check("mis_err",     32'(e),   32'h1);
        check("mis_rdata",   rd,       32'h0);
        check("mis_err_clr", 32'(err), 32'h0);
        access(1'b0, 32'h20, 32'h0, rd, e, lat);
        check("mis_nowrite", rd,       32'h33333333);

        // Aliasing of high address bits
        access(1'b1, 32'h104, 32'hA5A5A5A5, rd, e, lat);
        access(1'b0, 32'h004, 32'h0, rd, e, lat);
        check("alias_rdata", rd, 32'hA5A5A5A5);

        // Back-to-back with req held on the zero-wait instance
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'h55AA00FF;
        @(posedge clk); #1;
        check("w0_store_ack", 32'(ack0), 32'h1);
        req0 = 1'b0; we0 = 1'b0;
        @(posedge clk); #1;
        check("w0_idle_busy", 32'(busy0), 32'h0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
        @(posedge clk); #1;
        check("b2b_ack1",   32'(ack0),  32'h1);
        check("b2b_busy1",  32'(busy0), 32'h1);
        check("b2b_rdata1", rdata0,     32'h55AA00FF);
        @(posedge clk); #1;
        check("b2b_gap_ack",  32'(ack0),  32'h0);
        check("b2b_gap_busy", 32'(busy0), 32'h0);
        @(posedge clk); #1;
        check("b2b_ack2",  32'(ack0),  32'h1);
        check("b2b_busy2", 32'(busy0), 32'h1);
        req0 = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_ack", 32'(ack0), 32'h0);

        // Reset during WAIT drops the pending store
        access(1'b1, 32'h08, 32'h11111111, rd, e, lat);
        req = 1'b1; we = 1'b1; addr = 32'h08; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("rst_busy_pre", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rst_ack",  32'(ack),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        req = 1'b0; we = 1'b0;
        @(posedge clk); @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 32'h08, 32'h0, rd, e, lat);
        check("rst_drop", rd, 32'h11111111);

        // Input changes during WAIT are ignored
        access(1'b1, 32'h0C, 32'h0BADCAFE, rd, e, lat);
        access(1'b1, 32'h00, 32'h77777777, rd, e, lat);
        req = 1'b1; we = 1'b0; addr = 32'h0C; wdata = 32'h0;
        @(posedge clk); #1;
        addr = 32'h00; we = 1'b1; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        check("chg_wait_ack", 32'(ack), 32'h0);
        @(posedge clk); #1;
        check("chg_ack",   32'(ack), 32'h1);
        check("chg_rdata", rdata,    32'h0BADCAFE);
        req = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 32'h00, 32'h0, rd, e, lat);
        check("chg_word0", rd, 32'h77777777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
